// File: rtl/tpsr_be.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpsr_be : two-port SRAM (one write port, one read port) with byte enables,
//           1- or 2-cycle read latency, defined read-during-write result and
//           an optional zero-fill sequence after reset.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tpsr_be #(
  parameter int WORD_DEPTH     = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = DATA_WIDTH / BYTE_WIDTH,
  localparam int ADDR_WIDTH    = $clog2(WORD_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic                  init_done_o,
  input  logic                  wce_i,
  input  logic [ADDR_WIDTH-1:0] wa_i,
  input  logic [NB-1:0]         wbe_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic                  rce_i,
  input  logic [ADDR_WIDTH-1:0] ra_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  qv_o
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(WORD_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q;

  logic [DATA_WIDTH-1:0]   mem_q [WORD_DEPTH];

  logic                    wa_ok, ra_ok;
  logic                    wr_acc, rd_acc, clr_we, rdw_hit;
  logic [DATA_WIDTH-1:0]   rd_old, rd_merged, rd_word;

  logic                    cap_v_q;
  logic [DATA_WIDTH-1:0]   cap_q;
  logic                    last_v;
  logic [DATA_WIDTH-1:0]   last_d;
  logic                    qv_q;
  logic [DATA_WIDTH-1:0]   q_q;

  // Range checks collapse to constant 1 when the depth fills the address space.
  if (WORD_DEPTH == (1 << ADDR_WIDTH)) begin : g_pow2
    assign wa_ok = 1'b1;
    assign ra_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [ADDR_WIDTH-1:0] LIM = ADDR_WIDTH'(WORD_DEPTH);
    assign wa_ok = (wa_i < LIM);
    assign ra_ok = (ra_i < LIM);
  end

  // User operations only count once the block reports ready; the clear
  // sequence owns the write port while in CLEAR.
  assign wr_acc  = rstn_i & init_done_q & wce_i & wa_ok;
  assign rd_acc  = rstn_i & init_done_q & rce_i;
  assign clr_we  = rstn_i & (state_q == ST_CLEAR);
  assign rdw_hit = wr_acc & (wa_i == ra_i);

  // Read word selection: out-of-range reads return zero, and a same-address
  // write either is ignored (old data) or merged lane by lane (write-through).
  always_comb begin
    rd_old    = ra_ok ? mem_q[ra_i] : '0;
    rd_merged = rd_old;
    for (int i = 0; i < NB; i++) begin
      if (wbe_i[i]) rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wd_i[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    rd_word = ((RDW_MODE != 0) && rdw_hit) ? rd_merged : rd_old;
  end

  // Storage array write port, shared between the clear sequence and user writes.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe_i[i]) mem_q[wa_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Control state, clear counter and ready flag.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  // Next-state logic: RST -> CLEAR (walk every word) -> READY, or straight to READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RST: begin
        cnt_d   = '0;
        state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // First read stage: valid bit follows each accepted read, dropped on reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) cap_v_q <= 1'b0;
    else         cap_v_q <= rd_acc;
  end

  // First read stage data: the word as seen at the sampling edge.
  always_ff @(posedge clk_i) begin
    if (rd_acc) cap_q <= rd_word;
  end

  if (RD_LATENCY >= 2) begin : g_lat2
    logic                  mid_v_q;
    logic [DATA_WIDTH-1:0] mid_q;

    // Extra pipeline stage for the two-cycle latency option.
    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        mid_v_q <= 1'b0;
        mid_q   <= '0;
      end else begin
        mid_v_q <= cap_v_q;
        if (cap_v_q) mid_q <= cap_q;
      end
    end

    assign last_v = mid_v_q;
    assign last_d = mid_q;
  end else begin : g_lat1
    assign last_v = cap_v_q;
    assign last_d = cap_q;
  end

  // Output register: Q only moves on an edge that raises QV, otherwise holds.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      qv_q <= 1'b0;
      q_q  <= '0;
    end else begin
      qv_q <= last_v;
      if (last_v) q_q <= last_d;
    end
  end

  assign q_o         = q_q;
  assign qv_o        = qv_q;
  assign init_done_o = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tpsr_be.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tpsr_be : bench for tpsr_be. Two instances share stimulus:
//   dut0 : depth 256, latency 1, old-data read-during-write
//   dut1 : depth 100, latency 2, write-through read-during-write
// A behavioural memory model predicts INIT_DONE, QV and Q every cycle.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_tpsr_be;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wce, rce;
  logic [7:0]  wa, ra;
  logic [3:0]  wbe;
  logic [31:0] wd;

  logic        init0, qv0, init1, qv1;
  logic [31:0] q0, q1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tpsr_be #(.WORD_DEPTH(256), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RD_LATENCY(1),
            .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .init_done_o(init0),
    .wce_i(wce), .wa_i(wa), .wbe_i(wbe), .wd_i(wd),
    .rce_i(rce), .ra_i(ra), .q_o(q0), .qv_o(qv0));

  tpsr_be #(.WORD_DEPTH(100), .DATA_WIDTH(32), .BYTE_WIDTH(8), .RD_LATENCY(2),
            .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .init_done_o(init1),
    .wce_i(wce), .wa_i(wa[6:0]), .wbe_i(wbe), .wd_i(wd),
    .rce_i(rce), .ra_i(ra[6:0]), .q_o(q1), .qv_o(qv1));

  // ---------------- reference model ----------------
  logic [31:0] mm [2][256];
  int          rel [2];          // edges with reset released since last reset
  logic        ev [2][4];        // expected QV, indexed by due edge mod 4
  logic [31:0] ed [2][4];        // expected Q for that pulse
  logic [31:0] eq [2];           // expected held Q value
  int          e = 0;            // index of the most recent edge

  function automatic int dep(input int id); return (id == 0) ? 256 : 100; endfunction
  function automatic int lat(input int id); return (id == 0) ? 1 : 2; endfunction
  function automatic bit rdwm(input int id); return (id == 1); endfunction
  function automatic bit rdy(input int id); return rel[id] >= dep(id) + 1; endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic model_edge(input int id);
    int aw, ar, s;
    bit acc;
    logic [31:0] old, dat;
    aw = (id == 0) ? int'(wa) : int'(wa[6:0]);
    ar = (id == 0) ? int'(ra) : int'(ra[6:0]);
    if (!rstn) begin
      rel[id] = 0;
      for (int k = 0; k < 4; k++) ev[id][k] = 1'b0;
      eq[id] = 32'h0;
    end else begin
      acc = rdy(id);
      if (rel[id] >= 1 && rel[id] <= dep(id)) mm[id][rel[id]-1] = 32'h0;
      if (acc && rce) begin
        old = (ar < dep(id)) ? mm[id][ar] : 32'h0;
        dat = (rdwm(id) && wce && aw == ar && aw < dep(id)) ? merge(old, wd, wbe) : old;
        s = (e + lat(id)) & 3;
        ev[id][s] = 1'b1;
        ed[id][s] = dat;
      end
      if (acc && wce && aw < dep(id)) mm[id][aw] = merge(mm[id][aw], wd, wbe);
      if (rel[id] < 1000000) rel[id]++;
    end
  endtask

  always @(posedge clk) begin
    e++;
    for (int id = 0; id < 2; id++) model_edge(id);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int id = 0; id < 2; id++) begin
        int k;
        logic xv;
        k  = e & 3;
        xv = ev[id][k];
        if (xv) eq[id] = ed[id][k];
        ev[id][k] = 1'b0;
        chk($sformatf("dut%0d init_done", id), {31'b0, (id == 0) ? init0 : init1}, {31'b0, rdy(id)});
        chk($sformatf("dut%0d qv", id), {31'b0, (id == 0) ? qv0 : qv1}, {31'b0, xv});
        chk($sformatf("dut%0d q", id), (id == 0) ? q0 : q1, eq[id]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wce = 1'b0; rce = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    wce = 1'b1; wa = 8'(a); wd = d; wbe = be; rce = 1'b0;
    @(negedge clk);
    idle();
  endtask

  // Single read with literal expectations for both instances.
  task automatic read_lit(input string nm, input int a, input logic [31:0] x0, input logic [31:0] x1);
    rce = 1'b1; ra = 8'(a); wce = 1'b0;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk({nm, " dut0 qv"}, {31'b0, qv0}, 32'd1);
    chk({nm, " dut0 q"}, q0, x0);
    @(negedge clk);
    chk({nm, " dut1 qv"}, {31'b0, qv1}, 32'd1);
    chk({nm, " dut1 q"}, q1, x1);
  endtask

  task automatic wait_ready0(input string nm, input int expect_n);
    int n;
    n = 0;
    while (n < 600 && !init0) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready edges"}, 32'(n), 32'(expect_n));
  endtask

  initial begin
    rstn = 1'b0; wce = 1'b0; rce = 1'b0; wa = '0; ra = '0; wbe = '0; wd = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset init_done", {31'b0, init0}, 32'd0);
    chk("reset qv", {31'b0, qv0}, 32'd0);
    chk("reset q", q0, 32'd0);

    // Release; INIT_DONE must rise exactly after edge 256.
    rstn = 1'b1;
    repeat (256) @(negedge clk);
    chk("init before edge256", {31'b0, init0}, 32'd0);
    @(negedge clk);
    chk("init after edge256", {31'b0, init0}, 32'd1);

    // Pre-fill every word, then reset and confirm the clear zeroes it.
    for (int a = 0; a < 256; a++) wr(a, $urandom, 4'hF);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_ready0("clear", 257);
    read_lit("clr addr0", 0, 32'h0, 32'h0);
    read_lit("clr addr17", 17, 32'h0, 32'h0);
    read_lit("clr addr255", 255, 32'h0, 32'h0);

    // Byte enables.
    wr(5, 32'hAABBCCDD, 4'hF);
    wr(5, 32'h11223344, 4'b0101);
    read_lit("byte en", 5, 32'hAA22CC44, 32'hAA22CC44);

    // Read-during-write on word 9 (zero after clear).
    wce = 1'b1; wa = 8'd9; wd = 32'hFFFFFFFF; wbe = 4'b0011; rce = 1'b1; ra = 8'd9;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("rdw old dut0", q0, 32'h00000000);
    @(negedge clk);
    chk("rdw new dut1", q1, 32'h0000FFFF);
    read_lit("rdw after", 9, 32'h0000FFFF, 32'h0000FFFF);

    // Streaming reads of 0..7 through the 2-cycle instance.
    for (int a = 0; a < 8; a++) wr(a, 32'h10000000 + 32'(a) * 32'h01010101, 4'hF);
    for (int i = 0; i < 10; i++) begin
      rce = (i < 8); ra = 8'(i);
      @(negedge clk);
      if (i >= 2) begin
        chk("stream qv", {31'b0, qv1}, 32'd1);
        chk("stream q", q1, 32'h10000000 + 32'(i - 2) * 32'h01010101);
      end
    end
    idle();
    @(negedge clk);
    chk("stream qv end", {31'b0, qv1}, 32'd0);
    chk("stream q held", q1, 32'h17070707);

    // Reset at clear count 100: the clear must start over.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (101) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    wait_ready0("mid-clear", 257);

    // Reset with reads in flight.
    rce = 1'b1; ra = 8'd3;
    @(negedge clk);
    ra = 8'd4;
    @(negedge clk);
    idle();
    rstn = 1'b0;
    @(negedge clk);
    chk("inflight dut0 qv", {31'b0, qv0}, 32'd0);
    chk("inflight dut1 qv", {31'b0, qv1}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("inflight dut1 qv2", {31'b0, qv1}, 32'd0);
    wait_ready0("after inflight", 256);

    // Out-of-range handling on the depth-100 instance.
    wr(120, 32'hDEADBEEF, 4'hF);
    read_lit("oor 120", 120, 32'hDEADBEEF, 32'h0);
    read_lit("oor 99", 99, 32'h0, 32'h0);

    // Randomised traffic, concentrated on a few addresses to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      wce = 1'($urandom_range(0, 1));
      rce = 1'($urandom_range(0, 1));
      wa  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) ra = wa;
      wbe = 4'($urandom);
      wd  = $urandom;
      rstn = !(i == 1500 || i == 1501);
      @(negedge clk);
    end
    idle();
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tpsr_be.md
# tpsr_be

Parametrised two-port SRAM with one write port and one read port, per-byte write enables, selectable read latency (1 or 2), a defined read-during-write result, and an optional hardware clear sequence after reset. It is the successor to the generic single-port SRAM and serves as the buffer primitive for streaming kernels that must write and read in the same cycle. The storage array maps to FPGA block RAM; the control logic is plain fabric.

## Interface
- WORD_DEPTH, 256, number of words; any value ≥ 2, power of two not required
- DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
- RDW_MODE, 0, same-address read-during-write result; 0 = old data, 1 = new data (write-through)
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined, ready immediately
- ADDR_WIDTH (localparam), $clog2(WORD_DEPTH)
- CLK  in  1  clock; all logic on rising edge
- RSTN  in  1  reset; synchronous, active-low
- INIT_DONE  out  1  high when the block accepts operations
- WCE  in  1  write enable
- WA  in  ADDR_WIDTH  write address
- WBE  in  NB  byte-lane enables; bit i covers WD[i*BYTE_WIDTH +: BYTE_WIDTH]
- WD  in  DATA_WIDTH  write data
- RCE  in  1  read enable
- RA  in  ADDR_WIDTH  read address
- Q  out  DATA_WIDTH  read data
- QV  out  1  one-cycle pulse; Q holds valid read data

## Operation
- The control FSM has three states: RST, CLEAR and READY.
  - RST is entered on any edge where RSTN=0, including mid-clear and mid-read. It clears the clear counter, both read-pipeline valid bits, Q, QV and INIT_DONE.
  - On the first edge with RSTN=1, RST goes to CLEAR if CLEAR_ON_RESET=1, or to READY if CLEAR_ON_RESET=0.
  - In CLEAR, the block writes all zeros to word[cnt] on every edge, cnt = 0..WORD_DEPTH-1. After writing WORD_DEPTH-1 it goes to READY.
  - READY persists until RSTN=0.
- INIT_DONE is registered, equal to (state == READY).
- WCE and RCE are ignored unless INIT_DONE=1 at the sampling edge. Reads ignored this way produce no QV.
- Write: when WCE=1 and WA < WORD_DEPTH, each lane with WBE[i]=1 is updated. Lanes with WBE[i]=0 are unchanged. WBE=0 is a legal no-op.
- Read: when RCE=1, the block captures word[RA]. If RA ≥ WORD_DEPTH, the returned data is 0. Writes to out-of-range addresses are dropped.
- Read-during-write: applies when WCE=1, RCE=1 and WA == RA in the same cycle.
  - RDW_MODE=0: Q returns the pre-write word.
  - RDW_MODE=1: Q returns the merged word. Lanes with WBE=1 take WD; other lanes keep old data.
- Reads and writes to different addresses do not interact.
- Q holds its last value between reads. It changes only on an edge that raises QV.
- RSTN does not modify array contents except through the CLEAR sequence.

## Timing
- Reset values: INIT_DONE=0, QV=0, Q=0.
- Clear duration, with CLEAR_ON_RESET=1:
  - Edge 0 is the first edge with RSTN=1 (RST→CLEAR).
  - Edges 1..WORD_DEPTH write addresses 0..WORD_DEPTH-1.
  - INIT_DONE is 1 after edge WORD_DEPTH.
  - The first accepted operation is at edge WORD_DEPTH+1.
- Ready delay with CLEAR_ON_RESET=0: INIT_DONE=1 after edge 0.
- Read latency:
  - RCE sampled at edge N gives Q/QV valid after edge N+RD_LATENCY.
  - Fully pipelined: one read per cycle and back-to-back QV pulses.
- Write visibility: a write at edge N is visible to a read sampled at edge N+1 or later. Visibility at edge N itself is governed by RDW_MODE.
- Reset mid-clear restarts the count at address 0. Reset with reads in flight drops them, and no QV follows.

## Test plan
- Reset and clear, defaults:
  - Stimulus: pre-fill via back-door, then assert RSTN=0 for 2 cycles and release.
  - Response: INIT_DONE rises exactly after edge 256; reads of addresses 0, 17 and 255 return 0x00000000.
- Byte enables:
  - Stimulus: write 0xAABBCCDD to address 5 with WBE=4'hF, then write 0x11223344 to address 5 with WBE=4'b0101.
  - Response: reading address 5 returns 0xAA22CC44.
- Read-during-write:
  - Stimulus: word[9]=0x00000000; same cycle, WCE=1, WA=9, WD=0xFFFFFFFF, WBE=4'b0011, RCE=1, RA=9.
  - Response: RDW_MODE=0 gives Q=0x00000000; RDW_MODE=1 gives Q=0x0000FFFF. A following read returns 0x0000FFFF in both modes.
- Latency and streaming:
  - Stimulus: RD_LATENCY=2, RCE held high for addresses 0..7 on consecutive edges.
  - Response: 8 consecutive QV pulses starting 2 edges after the first RCE, with data in address order and Q stable afterwards.
- Reset mid-operation:
  - Stimulus: deassert RSTN for 1 cycle at clear count 100, and separately with 2 reads in flight.
  - Response: clear restarts, INIT_DONE takes a full 256 edges after release, and no QV appears for the dropped reads.
- Non-power-of-two depth:
  - Stimulus: WORD_DEPTH=100; write address 120, then read 120 and 99.
  - Response: address 120 returns 0; address 99 is unchanged (0 after clear).
